// File: rtl/change_sched.sv
// Coin-change dispense scheduler: pays change_amt (0.5 yuan units) one coin at a time via the 1 yuan / 0.5 yuan eject actuators.
// Latency: first coin decision one cycle after start; each coin takes 1 + PULSE_CYC + GAP_CYC cycles; done one cycle after the final decision.
// Backpressure: none; start is honoured only when idle or faulted and is otherwise ignored.
module change_sched #(
    parameter int PULSE_CYC = 50,
    parameter int GAP_CYC   = 100
) (
    input  logic       clk1k,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] change_amt,
    input  logic       empty_1y,
    input  logic       empty_5j,
    output logic       eject_1y,
    output logic       eject_5j,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] remain
);

    localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE,
        FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            eject_1y_nxt, eject_5j_nxt;
    logic            busy_nxt, done_nxt, fault_nxt;
    logic [7:0]      remain_nxt;

    // Register every output alongside the state so the actuators and display see glitch-free levels.
    always_ff @(posedge clk1k or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            timer    <= '0;
            eject_1y <= 1'b0;
            eject_5j <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            remain   <= 8'd0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            eject_1y <= eject_1y_nxt;
            eject_5j <= eject_5j_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            fault    <= fault_nxt;
            remain   <= remain_nxt;
        end
    end

    // Next-state and next-output decisions; coin choice happens only in the single SELECT cycle.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        eject_1y_nxt = eject_1y;
        eject_5j_nxt = eject_5j;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        fault_nxt    = fault;
        remain_nxt   = remain;

        case (state)
            IDLE, FAULT: begin
                if (start) begin
                    remain_nxt = change_amt;
                    fault_nxt  = 1'b0;
                    busy_nxt   = 1'b1;
                    state_nxt  = SELECT;
                end
            end

            SELECT: begin
                timer_nxt = '0;
                if (remain == 8'd0) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (remain >= 8'd2 && !empty_1y) begin
                    // 1 yuan only when at least two half-units are owed, so we never overpay.
                    eject_1y_nxt = 1'b1;
                    state_nxt    = PULSE;
                end else if (!empty_5j) begin
                    eject_5j_nxt = 1'b1;
                    state_nxt    = PULSE;
                end else begin
                    fault_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = FAULT;
                end
            end

            PULSE: begin
                if (timer == TW'(PULSE_CYC - 1)) begin
                    // The held eject line identifies which coin is in flight.
                    remain_nxt   = remain - (eject_1y ? 8'd2 : 8'd1);
                    eject_1y_nxt = 1'b0;
                    eject_5j_nxt = 1'b0;
                    timer_nxt    = '0;
                    state_nxt    = GAP;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            GAP: begin
                if (timer == TW'(GAP_CYC - 1)) begin
                    timer_nxt = '0;
                    state_nxt = SELECT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_change_sched.sv
// Testbench for change_sched: randomized transactions against a coin-list timeline model.
// Latency: expected outputs derived per cycle from the coin schedule arithmetic.
// Backpressure: n/a; stray starts injected mid-transaction must be ignored.
module tb_change_sched;

    localparam int P   = 50;
    localparam int G   = 100;
    localparam int PER = 1 + P + G;

    logic       clk1k = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic [7:0] change_amt = 8'd0;
    logic       empty_1y = 1'b0;
    logic       empty_5j = 1'b0;
    logic       eject_1y, eject_5j, busy, done, fault;
    logic [7:0] remain;

    int checks = 0;
    int failures = 0;

    // Model state for the current transaction.
    int coins[$];
    int m_amt;
    bit m_fault;
    int m_term;

    change_sched #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk1k      (clk1k),
        .clr        (clr),
        .start      (start),
        .change_amt (change_amt),
        .empty_1y   (empty_1y),
        .empty_5j   (empty_5j),
        .eject_1y   (eject_1y),
        .eject_5j   (eject_5j),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .remain     (remain)
    );

    always #5 clk1k = ~clk1k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [12:0] observed();
        return {eject_1y, eject_5j, busy, done, fault, remain};
    endfunction

    // Greedy coin list: flags (e1a,e5a) apply to the first decision, (e1b,e5b) to later ones.
    function automatic void plan(input int amt, input bit e1a, input bit e5a, input bit e1b, input bit e5b);
        int r;
        bit e1, e5;
        coins.delete();
        m_amt   = amt;
        m_fault = 1'b0;
        r = amt;
        while (1) begin
            e1 = (coins.size() == 0) ? e1a : e1b;
            e5 = (coins.size() == 0) ? e5a : e5b;
            if (r == 0) break;
            if (r >= 2 && !e1) coins.push_back(2);
            else if (!e5) coins.push_back(1);
            else begin
                m_fault = 1'b1;
                break;
            end
            r -= coins[coins.size()-1];
        end
        m_term = PER * coins.size() + 2;
    endfunction

    // Expected outputs in cycle n (cycle 1 follows the edge that accepted start).
    function automatic logic [12:0] expect_at(input int n);
        logic e1 = 1'b0, e5 = 1'b0, b, d, f;
        int rem = m_amt;
        for (int k = 0; k < coins.size(); k++) begin
            if (n >= 2 + PER*k && n <= 1 + P + PER*k) begin
                if (coins[k] == 2) e1 = 1'b1;
                else e5 = 1'b1;
            end
            if (n >= 2 + P + PER*k) rem -= coins[k];
        end
        if (m_fault) begin
            b = (n < m_term);
            d = 1'b0;
            f = (n >= m_term);
        end else begin
            b = (n <= m_term);
            d = (n == m_term);
            f = 1'b0;
        end
        return {e1, e5, b, d, f, 8'(rem)};
    endfunction

    task automatic run_txn(input int amt, input bit e1a, input bit e5a, input bit e1b, input bit e5b,
                           input int flip_cyc, input int poke_cyc, input bit rnd_poke, input int stop_cyc);
        int last, busy_last;
        plan(amt, e1a, e5a, e1b, e5b);
        @(negedge clk1k);
        start      = 1'b1;
        change_amt = 8'(amt);
        empty_1y   = e1a;
        empty_5j   = e5a;
        last       = (stop_cyc > 0) ? stop_cyc : m_term + 3;
        busy_last  = m_fault ? m_term - 1 : m_term;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk1k);
            start      = 1'b0;
            change_amt = 8'($urandom);
            chk($sformatf("cyc%0d_amt%0d", n, amt), 32'(observed()), 32'(expect_at(n)));
            if (n == flip_cyc) begin
                empty_1y = e1b;
                empty_5j = e5b;
            end
            if (n < busy_last && (n == poke_cyc || (rnd_poke && $urandom_range(0, 99) == 0))) begin
                start      = 1'b1;
                change_amt = 8'($urandom_range(1, 255));
            end
        end
    endtask

    initial begin
        int amt;
        bit e1a, e5a, e1b, e5b;
        int fc;

        #1;
        chk("reset_outputs", 32'(observed()), 32'd0);
        repeat (2) @(negedge clk1k);
        clr = 1'b1;
        @(negedge clk1k);
        chk("idle_after_reset", 32'(observed()), 32'd0);

        // Directed cases from the scheduling rules.
        run_txn(5, 0, 0, 0, 0, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_txn(4, 1, 0, 1, 0, 0, 0, 0, 0);
        run_txn(3, 1, 1, 1, 1, 0, 0, 0, 0);
        run_txn(3, 1, 0, 1, 0, 0, 0, 0, 0);
        run_txn(2, 0, 1, 1, 1, 20, 0, 0, 0);
        run_txn(5, 0, 0, 0, 0, 0, 10, 0, 0);
        run_txn(1, 0, 0, 0, 0, 0, 1, 0, 0);

        // Asynchronous clear in the middle of a 1-yuan pulse.
        run_txn(5, 0, 0, 0, 0, 0, 0, 0, 20);
        #2;
        clr = 1'b0;
        #1;
        chk("clr_async_drop", 32'(observed()), 32'd0);
        @(posedge clk1k);
        #1;
        chk("clr_held", 32'(observed()), 32'd0);
        @(negedge clk1k);
        clr = 1'b1;
        @(negedge clk1k);
        chk("idle_after_clr", 32'(observed()), 32'd0);

        // Randomized transactions, some with hopper flags changing during the first coin.
        for (int t = 0; t < 16; t++) begin
            amt = $urandom_range(0, 9);
            e1a = 1'($urandom_range(0, 1));
            e5a = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                e1b = 1'($urandom_range(0, 1));
                e5b = ($urandom_range(0, 3) == 0);
                fc  = $urandom_range(2, PER);
            end else begin
                e1b = e1a;
                e5b = e5a;
                fc  = 0;
            end
            run_txn(amt, e1a, e5a, e1b, e5b, fc, 0, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/change_sched.md
# change_sched

Coin-change dispense scheduler for the vending machine. When the transaction state machine finishes a sale, it issues a one-cycle start with the change owed. This block then sequences the two coin-eject actuators (1 yuan and 0.5 yuan hoppers) one coin at a time, with fixed pulse and gap timing. It falls back to 0.5-yuan coins when the 1-yuan hopper is empty, and reports done, fault and the remaining amount for the seven-segment display path. It runs in the 1 kHz domain next to the key debouncer, transaction FSM and display driver.

## Interface
- PULSE_CYC, 50: cycles an eject output is held high per coin (50 ms at 1 kHz).
- GAP_CYC, 100: low cycles after each pulse before the next coin decision.
- clk1k  input  1  1 kHz system clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request, sampled only in IDLE or FAULT.
- change_amt  input  8  change owed, unit 0.5 yuan (5 = 2.5 yuan); sampled with start.
- empty_1y  input  1  1-yuan hopper empty, sampled only in SELECT.
- empty_5j  input  1  0.5-yuan hopper empty, sampled only in SELECT.
- eject_1y  output  1  1-yuan eject actuator drive.
- eject_5j  output  1  0.5-yuan eject actuator drive.
- busy  output  1  high from cycle after accepted start until done pulse inclusive.
- done  output  1  one-cycle pulse, all change paid.
- fault  output  1  level, change cannot be completed; held until clr low or next accepted start.
- remain  output  8  change still owed, unit 0.5 yuan.

## Operation
- All outputs are registered.
- Reset values:
  - State is IDLE.
  - eject_1y, eject_5j, busy, done and fault are 0.
  - remain is 0.
  - The timer is 0.
- States: IDLE, SELECT, PULSE, GAP, DONE, FAULT.
- IDLE or FAULT with start=1:
  - remain <= change_amt; fault <= 0; busy <= 1; go to SELECT.
  - start in any other state is ignored.
- SELECT (exactly one cycle), first matching rule wins:
  - remain==0 -> DONE.
  - remain>=2 and !empty_1y -> eject_1y <= 1, coin=2, go to PULSE.
  - !empty_5j -> eject_5j <= 1, coin=1, go to PULSE.
  - Otherwise -> FAULT: fault <= 1, busy <= 0, remain unchanged.
  - A 1-yuan coin is never used for remain==1; no overpayment.
- PULSE:
  - The eject output stays high for exactly PULSE_CYC cycles.
  - On leaving PULSE: eject low, remain <= remain - coin, go to GAP.
- GAP: exactly GAP_CYC cycles with both ejects low, then go to SELECT.
- DONE: done=1 for one cycle, busy=1; next state IDLE, where busy=0.
- Hopper flags change mid-pulse or mid-gap: the current coin completes; the new flags take effect at the next SELECT.
- eject_1y and eject_5j are never high together.
- remain never underflows.
- clr low at any point forces the reset values immediately, dropping any active eject. No coin in flight is counted.

## Timing
- start sampled at edge E0. Cycle n denotes the period after edge En.
- Cycle 1 is SELECT.
- Eject high cycles 2..PULSE_CYC+1.
- remain updates at the edge ending the last pulse cycle.
- Gap cycles follow; next SELECT at cycle 1 + k·(1+PULSE_CYC+GAP_CYC) for coin k (k from 0).
- With defaults, each coin takes 151 cycles.
- For N coins: done high in cycle 151·N + 2, busy low from cycle 151·N + 3.
- Zero change: done in cycle 2.
- Fault: fault high from the cycle after the failing SELECT.

## Test plan
- change_amt=5, both hoppers full, defaults:
  - eject_1y high cycles 2..51 and 153..202.
  - eject_5j high cycles 304..353.
  - remain 5→3→1→0.
  - done in cycle 455 only; busy low from 456.
- change_amt=0 -> no eject; done in cycle 2; busy high cycles 1..2.
- change_amt=4, empty_1y=1 -> four eject_5j pulses, no eject_1y; done in cycle 606.
- change_amt=3, both empty -> fault=1 from cycle 2, remain=3, busy=0.
  - A new start with empty_5j=0 clears fault and proceeds.
- change_amt=2, empty_1y=0, empty_5j=1; empty_1y asserted during first pulse:
  - Pulse completes; remain=0; done in cycle 153.
- Reset and start robustness:
  - A second start during PULSE is ignored; remain is unaffected.
  - clr driven low mid-PULSE -> eject low and all outputs at reset values without waiting for a clock edge.
